// File: rtl/mux_scan_sequencer.sv
// Sweeps mux SELECT across all channels, samples MUX_OUT after a settle time, and delivers the word via valid/ready.
// Optional macro SCAN_MASK_EN adds ch_mask_i to skip disabled channels.
module mux_scan_sequencer #(
  parameter int NUM_CH        = 4,
  parameter int SEL_W         = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              mux_out_i,
`ifdef SCAN_MASK_EN
  input  logic [NUM_CH-1:0] ch_mask_i,
`endif
  output logic [SEL_W-1:0]  select_o,
  output logic              busy_o,
  output logic [NUM_CH-1:0] scan_data_o,
  output logic              scan_valid_o,
  input  logic              scan_ready_i,
  output logic              start_err_o
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_VALID} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0]  work_q, work_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_CH-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic [NUM_CH-1:0]  start_mask;
  logic [NUM_CH-1:0]  scan_mask;

`ifdef SCAN_MASK_EN
  logic [NUM_CH-1:0]  mask_q;

  assign start_mask = ch_mask_i;
  assign scan_mask  = mask_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mask_q <= '0;
    end else if (state_q == S_IDLE && start_i) begin
      mask_q <= ch_mask_i;
    end
  end
`else
  assign start_mask = '1;
  assign scan_mask  = '1;
`endif

  logic             first_vld;
  logic [SEL_W-1:0] first_ch;
  logic             next_vld;
  logic [SEL_W-1:0] next_ch;
  logic             capture;

  // Descending loops so the lowest qualifying channel wins.
  always_comb begin
    first_vld = 1'b0;
    first_ch  = '0;
    next_vld  = 1'b0;
    next_ch   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (start_mask[i]) begin
        first_vld = 1'b1;
        first_ch  = SEL_W'(i);
      end
      if (scan_mask[i] && (i > int'(ch_q))) begin
        next_vld = 1'b1;
        next_ch  = SEL_W'(i);
      end
    end
  end

  assign capture = (cnt_q == '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_SCAN;
      S_SCAN:  if (capture && !next_vld) state_d = S_VALID;
      S_VALID: if (scan_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    // A START coinciding with the handshake is silently dropped.
    err_d   = start_i && ((state_q == S_SCAN) ||
                          (state_q == S_VALID && !scan_ready_i));
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          ch_d   = first_ch;
          sel_d  = first_ch;
          cnt_d  = first_vld ? SETTLE_V : '0;
          work_d = '0;
          busy_d = 1'b1;
        end
      end
      S_SCAN: begin
        if (!capture) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (scan_mask[ch_q]) work_d[ch_q] = mux_out_i;
          if (next_vld) begin
            ch_d  = next_ch;
            sel_d = next_ch;
            cnt_d = SETTLE_V;
          end else begin
            data_d  = work_d;
            valid_d = 1'b1;
            sel_d   = '0;
            ch_d    = '0;
          end
        end
      end
      S_VALID: begin
        if (scan_ready_i) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ch_q    <= '0;
      cnt_q   <= '0;
      work_q  <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign select_o     = sel_q;
  assign busy_o       = busy_q;
  assign scan_data_o  = data_q;
  assign scan_valid_o = valid_q;
  assign start_err_o  = err_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: directed test-plan cases plus randomized scans against a cycle-count model.
module tb_mux_scan_sequencer;
  localparam int N = 4;
  localparam int S = 1;
  localparam int L = N * (S + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start, ready, mux_out, busy, valid, err;
  logic [N-1:0] data_in, sdata;
  logic [1:0]   sel;

  logic         start0, ready0, mux_out0, busy0, valid0, err0;
  logic [N-1:0] data_in0, sdata0;
  logic [1:0]   sel0;
`ifdef SCAN_MASK_EN
  logic [N-1:0] ch_mask, ch_mask0;
`endif

  assign mux_out  = data_in[sel];
  assign mux_out0 = data_in0[sel0];

  mux_scan_sequencer #(.NUM_CH(N), .SEL_W(2), .SETTLE_CYCLES(S)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .mux_out_i(mux_out),
`ifdef SCAN_MASK_EN
    .ch_mask_i(ch_mask),
`endif
    .select_o(sel), .busy_o(busy), .scan_data_o(sdata), .scan_valid_o(valid),
    .scan_ready_i(ready), .start_err_o(err)
  );

  mux_scan_sequencer #(.NUM_CH(N), .SEL_W(2), .SETTLE_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start0), .mux_out_i(mux_out0),
`ifdef SCAN_MASK_EN
    .ch_mask_i(ch_mask0),
`endif
    .select_o(sel0), .busy_o(busy0), .scan_data_o(sdata0), .scan_valid_o(valid0),
    .scan_ready_i(ready0), .start_err_o(err0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: channel k/(S+1) is on SELECT during scan cycle k; channel i is
  // captured from the mux input present at edge (i+1)*(S+1).
  task automatic run_scan(input bit rnd_data, input logic [N-1:0] fix_data,
                          input bit poke_rnd, input int poke_at, input int hold);
    logic [N-1:0] exp_d;
    bit           exp_err;
    int           ch;
    data_in = rnd_data ? N'($urandom) : fix_data;
    start   = 1'b1;
    ready   = 1'b0;
    step();
    start   = 1'b0;
    exp_d   = '0;
    exp_err = 1'b0;
    for (int k = 0; k < L; k++) begin
      chk("sel", 32'(sel), 32'(k / (S + 1)));
      chk("busy", 32'(busy), 32'd1);
      chk("valid_lo", 32'(valid), 32'd0);
      chk("start_err", 32'(err), 32'(exp_err));
      if (rnd_data) data_in = N'($urandom);
      start   = (k == poke_at) || (poke_rnd && ($urandom_range(0, 3) == 0));
      exp_err = start;
      if ((k + 1) % (S + 1) == 0) begin
        ch = (k + 1) / (S + 1) - 1;
        exp_d[ch] = data_in[ch];
      end
      step();
    end
    chk("valid_hi", 32'(valid), 32'd1);
    chk("data", 32'(sdata), 32'(exp_d));
    chk("sel_done", 32'(sel), 32'd0);
    chk("busy_done", 32'(busy), 32'd1);
    chk("start_err_end", 32'(err), 32'(exp_err));
    for (int d = 0; d < hold; d++) begin
      start   = poke_rnd && ($urandom_range(0, 1) == 0);
      exp_err = start;
      if (rnd_data) data_in = N'($urandom);
      step();
      chk("hold_valid", 32'(valid), 32'd1);
      chk("hold_data", 32'(sdata), 32'(exp_d));
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_err", 32'(err), 32'(exp_err));
    end
    ready = 1'b1;
    start = poke_rnd && ($urandom_range(0, 1) == 0);
    step();
    ready = 1'b0;
    start = 1'b0;
    chk("hs_valid", 32'(valid), 32'd0);
    chk("hs_busy", 32'(busy), 32'd0);
    chk("hs_data", 32'(sdata), 32'(exp_d));
    chk("hs_err", 32'(err), 32'd0);
    step();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_err", 32'(err), 32'd0);
  endtask

  initial begin
    int exp_sel[4];
    rst_n = 1'b0; start = 1'b0; ready = 1'b0; data_in = '0;
    start0 = 1'b0; ready0 = 1'b0; data_in0 = '0;
`ifdef SCAN_MASK_EN
    ch_mask = '1; ch_mask0 = '1;
`endif
    #12;
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(sdata), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_scan(1'b0, 4'b1010, 1'b0, -1, 5);
    run_scan(1'b0, 4'b1010, 1'b0, 2, 0);

    // Reset in the middle of a scan.
    data_in = 4'b1111;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", 32'(sel), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", 32'(sdata), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_scan(1'b0, 4'b0110, 1'b0, -1, 0);

    // Zero settle time: mux input switches after edge 2.
    data_in0 = 4'b0000;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk("s0_sel", 32'(sel0), 32'(k));
      chk("s0_valid_lo", 32'(valid0), 32'd0);
      if (k == 2) data_in0 = 4'b1111;
      step();
    end
    chk("s0_valid_hi", 32'(valid0), 32'd1);
    chk("s0_data", 32'(sdata0), 32'h0000_000c);
    ready0 = 1'b1;
    step();
    ready0 = 1'b0;
    chk("s0_hs_valid", 32'(valid0), 32'd0);
    chk("s0_hs_busy", 32'(busy0), 32'd0);
    chk("s0_hs_data", 32'(sdata0), 32'h0000_000c);

`ifdef SCAN_MASK_EN
    exp_sel = '{0, 0, 2, 2};
    ch_mask = 4'b0101;
    data_in = 4'b1111;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("mask_sel", 32'(sel), 32'(exp_sel[k]));
      chk("mask_valid_lo", 32'(valid), 32'd0);
      step();
    end
    chk("mask_valid_hi", 32'(valid), 32'd1);
    chk("mask_data", 32'(sdata), 32'h0000_0005);
    ready = 1'b1; step(); ready = 1'b0;
    ch_mask = 4'b0000;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("mask0_valid_lo", 32'(valid), 32'd0);
    step();
    chk("mask0_valid_hi", 32'(valid), 32'd1);
    chk("mask0_data", 32'(sdata), 32'd0);
    ready = 1'b1; step(); ready = 1'b0;
    ch_mask = '1;
    step();
`else
    exp_sel = '{0, 0, 0, 0};
    chk("cfg_sel0", 32'(exp_sel[0]), 32'(sel));
`endif

    repeat (40) run_scan(1'b1, '0, 1'b1, -1, int'($urandom_range(0, 4)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
